onets_dma_s2mm_arb: RTL
=======================

# onets_dma_s2mm_arb

Packet-granular round-robin arbiter sharing the single AXI DMA S2MM stream input between the two 10G port receive paths (port 0, port 1). Sits in the PL between the port RX FIFOs and the DMA slave stream interface in the 125 MHz fabric clock domain. Tags each forwarded packet with its source port and counts packets per port. Optionally enforces a maximum packet length so a runaway source cannot hold the DMA indefinitely.

## Interface
- DATA_W, 32: stream data width in bits.
- MAX_BEATS, 512: max beats per packet when the watchdog is compiled in; range 2..65535.
- CNT_W, 16: width of the status counters.

- clk  in  1  fabric clock (bd_fclk0_125m domain); all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- s0_tdata / s1_tdata  in  DATA_W  port 0 / port 1 data.
- s0_tvalid / s1_tvalid  in  1  source valid.
- s0_tlast / s1_tlast  in  1  last beat of packet.
- s0_tready / s1_tready  out  1  source ready.
- m_tdata  out  DATA_W  data to DMA.
- m_tvalid  out  1  valid to DMA.
- m_tlast  out  1  last beat to DMA.
- m_tuser  out  1  source port of the current packet (0 or 1).
- m_tready  in  1  DMA ready.
- pkt_cnt0 / pkt_cnt1  out  CNT_W  packets forwarded per port.
- trunc_cnt  out  CNT_W  packets truncated by the watchdog.
- busy  out  1  high while a packet is granted or draining.

## Operation
- FSM states: IDLE, GRANT0, GRANT1, DRAIN0, DRAIN1.
- IDLE: all tready low, m_tvalid low. Requests are sX_tvalid. One request → go to GRANTx. Both → grant port != last_grant. None → stay.
- last_grant register: reset value 1, so port 0 wins the first simultaneous request. Updated to x on entry to GRANTx.
- GRANTx: combinational passthrough. m_tdata/m_tlast = sX, m_tvalid = sX_tvalid, sX_tready = m_tready, other source tready = 0, m_tuser = x. Requests from the other port are ignored until the packet ends.
- Beat = sX_tvalid & m_tready. A beat with tlast → pkt_cntx += 1 (wraps modulo 2^CNT_W), go to IDLE.
- Beat counter: cleared on entry to GRANTx, increments per beat; width ceil(log2(MAX_BEATS+1)).
- busy = state != IDLE.
- Outputs are don't-care when m_tvalid is low, except m_tuser, which holds the last granted port.

## Timing
- Reset values: state IDLE, all tready 0, m_tvalid 0, m_tlast 0, m_tuser 0, busy 0, all counters 0, last_grant 1, beat counter 0.
- Arbitration latency: 1 cycle. A request sampled in IDLE at cycle n allows its first beat at cycle n+1.
- One idle bubble cycle follows every packet; the maximum sustained rate is therefore one packet per (beats+1) cycles.
- Single-beat packet (tvalid & tlast in the first granted cycle) is legal: GRANTx lasts one cycle.
- m_tready low stalls the source with no lost beats, because the ready path is combinational.
- reset_n asserted mid-packet: immediate return to reset values. The partial packet to the DMA is not terminated; software resets the DMA too.

## Configuration
- ONETS_ARB_WATCHDOG_EN defined:
  - In GRANTx, beat MAX_BEATS without sX_tlast drives m_tlast = 1 on that beat (truncation), increments trunc_cnt and pkt_cntx, and goes to DRAINx.
  - DRAINx: sX_tready = 1, m_tvalid = 0, beats are discarded. A beat with sX_tlast returns to IDLE.
  - A source tlast landing exactly on beat MAX_BEATS is not a truncation.
- Undefined:
  - No length limit, DRAIN states are absent, and trunc_cnt is tied to 0.

## Test plan
- Reset then only s0 sends a 4-beat packet, m_tready=1 → first beat the cycle after s0_tvalid rises, 4 beats with m_tuser=0, m_tlast on beat 4, pkt_cnt0=1, busy low the cycle after.
- s0 and s1 both request continuously with 3-beat packets → grant order 0,1,0,1; one bubble between packets; after 4 packets pkt_cnt0=2, pkt_cnt1=2.
- s1 granted, m_tready toggled every cycle during a 5-beat packet → all 5 data words arrive in order; s0_tready stays 0 throughout.
- Single-beat packets alternating from both ports → each occupies one grant cycle plus one idle cycle; m_tlast=1 on every beat.
- With ONETS_ARB_WATCHDOG_EN and MAX_BEATS=8, s0 sends 12 beats → DMA sees 8 beats with tlast on beat 8; beats 9-12 are consumed silently; trunc_cnt=1, pkt_cnt0=1. A 7-beat packet is not truncated.
- reset_n pulsed low during beat 3 of a packet → all outputs return to reset values asynchronously; the next request after release arbitrates from IDLE with port 0 winning a tie.

Source files
------------

// File: rtl/onets_dma_s2mm_arb.sv
// Packet-granular round-robin arbiter feeding the DMA S2MM stream from two port RX paths.
// Optional max-packet-length watchdog is compiled in with `define ONETS_ARB_WATCHDOG_EN.
module onets_dma_s2mm_arb #(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 512,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic              s0_tvalid,
  input  logic              s0_tlast,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic              s1_tvalid,
  input  logic              s1_tlast,
  output logic              s1_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  output logic              m_tuser,
  input  logic              m_tready,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic [CNT_W-1:0]  trunc_cnt,
  output logic              busy
);

  localparam int BEAT_W = $clog2(MAX_BEATS + 1);

`ifdef ONETS_ARB_WATCHDOG_EN
  typedef enum logic [2:0] {IDLE, GRANT0, GRANT1, DRAIN0, DRAIN1} state_t;
`else
  typedef enum logic [2:0] {IDLE, GRANT0, GRANT1} state_t;
`endif

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                tuser_q, tuser_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [CNT_W-1:0]    cnt0_q, cnt0_d;
  logic [CNT_W-1:0]    cnt1_q, cnt1_d;

  logic                pick;
  logic                src_v, src_l, src_rdy, beat;
  logic [DATA_W-1:0]   src_d;

  // Beat counter saturates so an unbounded packet never wraps it.
  function automatic logic [BEAT_W-1:0] sat_inc(input logic [BEAT_W-1:0] v);
    if (v == BEAT_W'(MAX_BEATS)) return v;
    return v + 1'b1;
  endfunction

`ifdef ONETS_ARB_WATCHDOG_EN
  logic [CNT_W-1:0] trunc_q, trunc_d;
  logic             trunc_hit;
  assign trunc_cnt = trunc_q;
`else
  assign trunc_cnt = '0;
`endif

  // During GRANT/DRAIN the active source is always the registered tuser.
  assign src_v = tuser_q ? s1_tvalid : s0_tvalid;
  assign src_l = tuser_q ? s1_tlast  : s0_tlast;
  assign src_d = tuser_q ? s1_tdata  : s0_tdata;

  assign s0_tready = src_rdy & ~tuser_q;
  assign s1_tready = src_rdy &  tuser_q;
  assign m_tdata   = src_d;
  assign m_tuser   = tuser_q;
  assign pkt_cnt0  = cnt0_q;
  assign pkt_cnt1  = cnt1_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      tuser_q      <= 1'b0;
      beat_q       <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
`ifdef ONETS_ARB_WATCHDOG_EN
      trunc_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tuser_q      <= tuser_d;
      beat_q       <= beat_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
`ifdef ONETS_ARB_WATCHDOG_EN
      trunc_q      <= trunc_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    tuser_d      = tuser_q;
    beat_d       = beat_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    pick         = 1'b0;
    src_rdy      = 1'b0;
    beat         = 1'b0;
    m_tvalid     = 1'b0;
    m_tlast      = 1'b0;
`ifdef ONETS_ARB_WATCHDOG_EN
    trunc_d      = trunc_q;
    trunc_hit    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time goes next.
        pick = (s0_tvalid & s1_tvalid) ? ~last_grant_q : s1_tvalid;
        if (s0_tvalid | s1_tvalid) begin
          state_d      = pick ? GRANT1 : GRANT0;
          last_grant_d = pick;
          tuser_d      = pick;
          beat_d       = '0;
        end
      end

      GRANT0, GRANT1: begin
        m_tvalid = src_v;
        m_tlast  = src_l;
        src_rdy  = m_tready;
        beat     = src_v & m_tready;
        if (beat) begin
          beat_d = sat_inc(beat_q);
`ifdef ONETS_ARB_WATCHDOG_EN
          trunc_hit = ~src_l & (beat_q == BEAT_W'(MAX_BEATS - 1));
          if (trunc_hit) begin
            m_tlast = 1'b1;
            trunc_d = trunc_q + 1'b1;
            state_d = tuser_q ? DRAIN1 : DRAIN0;
          end
          if (src_l | trunc_hit) begin
`else
          if (src_l) begin
`endif
            if (tuser_q) cnt1_d = cnt1_q + 1'b1;
            else         cnt0_d = cnt0_q + 1'b1;
          end
          if (src_l) state_d = IDLE;
        end
      end

`ifdef ONETS_ARB_WATCHDOG_EN
      // Discard the rest of a truncated packet without involving the DMA.
      DRAIN0, DRAIN1: begin
        src_rdy = 1'b1;
        if (src_v & src_l) state_d = IDLE;
      end
`endif

      default: state_d = IDLE;
    endcase
  end

endmodule
